time_surface_encoder_mc: RTL and testbench
==========================================

Name: time_surface_encoder_mc

Overview:
Multi-channel (per-polarity) exponential-decay time surface with on-chip timestamp storage, valid bits and fractional half-life interpolation. Sits between the event decoder and the feature-scan/flatten stage. Successor to the single-channel encoder: adds a channel dimension, event handshake, a hardware clear sweep, stale/wrap protection and sub-half-life decay resolution.

Parameters:
GRID_SIZE, 32, grid dimension (GRID_SIZE x GRID_SIZE cells per channel)
NUM_CH, 2, number of channels (polarities); power of two, >=1
TS_BITS, 16, timestamp width
VALUE_BITS, 8, surface value width
MAX_VALUE, 255, value at dt=0
DECAY_SHIFT, 6, log2(half-life in ticks); must be >= FRAC_BITS
FRAC_BITS, 2, fractional half-life bits used for mantissa LUT (0 = pure shift)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
t_now  in  TS_BITS  global timestamp
event_valid  in  1  event offered
event_ready  out  1  event accepted when valid&ready
event_ch  in  max(1,$clog2(NUM_CH))  channel/polarity
event_x  in  $clog2(GRID_SIZE)  grid X
event_y  in  $clog2(GRID_SIZE)  grid Y
event_ts  in  TS_BITS  event timestamp
read_enable  in  1  read request (accepted when read_ready)
read_ready  out  1  read may be issued
read_ch  in  max(1,$clog2(NUM_CH))  read channel
read_addr  in  $clog2(GRID_SIZE*GRID_SIZE)  {y,x} cell index
read_valid  out  1  read_value valid
read_value  out  VALUE_BITS  decayed surface value
read_ts_raw  out  TS_BITS  stored timestamp (debug)
clear_start  in  1  pulse: start memory clear sweep
busy  out  1  clear sweep in progress
event_count  out  16  accepted-event counter (Optional Feature)

Behaviour:
- Storage: NUM_CH*GRID_SIZE^2 words of {valid, ts}; word address = {ch, y, x}. Dual-port: one write, one read per cycle.
- Reset (async, rst_n=0): event_ready=0, read_ready=0, read_valid=0, read_value=0, read_ts_raw=0, busy=1, event_count=0; FSM forced to CLEAR, sweep pointer=0.
- FSM: CLEAR -> IDLE. CLEAR writes valid=0 to one word per cycle, pointer 0..depth-1; after last word -> IDLE (busy=0 next cycle). Clear takes exactly NUM_CH*GRID_SIZE^2 cycles. IDLE + clear_start -> CLEAR, pointer reset to 0. clear_start during CLEAR restarts sweep from 0.
- event_ready = read_ready = (state==IDLE). In IDLE, each accepted event writes {1, event_ts} to its word in the same cycle; no buffering. Events not accepted during CLEAR are the source's responsibility.
- Read pipeline, fixed latency 2: cycle N accept; N+1 word registered and dt = (t_now - ts) mod 2^TS_BITS computed with t_now sampled at N+1; N+2 read_valid=1 with read_value, read_ts_raw. Fully pipelined, one read per cycle. Reads in flight when clear_start arrives complete normally.
- Read-during-write same word, same cycle: read returns old word.
- Decay: steps = dt >> DECAY_SHIFT; frac = dt[DECAY_SHIFT-1 -: FRAC_BITS]; mant = LUT[frac] = round(MAX_VALUE*2^(-frac/2^FRAC_BITS)); read_value = mant >> steps.
- Zero cases: valid=0 -> 0; steps >= VALUE_BITS -> 0; dt >= 2^(TS_BITS-1) (stale/aliased) -> 0.
- Default LUT: 255, 214, 180, 152.
- Simultaneous event to same cell twice in consecutive cycles: last write wins.

Optional Feature:
TSE_EVENT_COUNT_EN: defined -> event_count increments on each accepted event, saturates at 65535, zeroed on reset and on entry to CLEAR. Undefined -> event_count tied to 0, no counter logic.

Test Plan:
- Reset release -> busy=1 for exactly 2048 cycles, event_ready=0 throughout, then busy=0, event_ready=1; read any cell -> 0.
- Event ch0 (x=3,y=5) ts=1000; read at t_now=1000 -> 255; t_now=1064 -> 127; t_now=1096 -> 90; t_now=1512 -> 0; read_valid exactly 2 cycles after read_enable.
- Event ch1 cell 0 ts=65500; read at t_now=36 (wrap, dt=72) -> 127, read_ts_raw=65500; ch0 cell 0 reads 0.
- Stale: ts=0, t_now=40000 -> 0; back-to-back reads of 4 addresses -> 4 consecutive read_valid cycles, in order.
- clear_start after writes -> busy 2048 cycles, events offered during sweep not accepted, all cells read 0 afterwards; rst_n low mid-sweep restarts sweep from 0.
- TSE_EVENT_COUNT_EN defined: 10 accepted events -> event_count=10; clear -> 0; undefined -> stays 0.

Source files
------------

// File: rtl/time_surface_encoder_mc.sv
// rtl/time_surface_encoder_mc.sv - per-channel exponential-decay time surface with clear sweep and fractional decay
// Optional accepted-event counter enabled by defining TSE_EVENT_COUNT_EN.
module time_surface_encoder_mc #(
  parameter int GRID_SIZE   = 32,
  parameter int NUM_CH      = 2,
  parameter int TS_BITS     = 16,
  parameter int VALUE_BITS  = 8,
  parameter int MAX_VALUE   = 255,
  parameter int DECAY_SHIFT = 6,
  parameter int FRAC_BITS   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [TS_BITS-1:0]                     t_now,
  input  logic                                   event_valid,
  output logic                                   event_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] event_ch,
  input  logic [$clog2(GRID_SIZE)-1:0]           event_x,
  input  logic [$clog2(GRID_SIZE)-1:0]           event_y,
  input  logic [TS_BITS-1:0]                     event_ts,
  input  logic                                   read_enable,
  output logic                                   read_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] read_ch,
  input  logic [$clog2(GRID_SIZE*GRID_SIZE)-1:0] read_addr,
  output logic                                   read_valid,
  output logic [VALUE_BITS-1:0]                  read_value,
  output logic [TS_BITS-1:0]                     read_ts_raw,
  input  logic                                   clear_start,
  output logic                                   busy,
  output logic [15:0]                            event_count
);

  localparam int DEPTH  = NUM_CH * GRID_SIZE * GRID_SIZE;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int STEP_W = TS_BITS - DECAY_SHIFT;
  localparam int LUT_N  = 1 << FRAC_BITS;
  localparam int FI_W   = (FRAC_BITS > 0) ? FRAC_BITS : 1;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              state;
  logic [MEM_AW-1:0]   ptr;
  logic                ready;
  logic [TS_BITS:0]    mem [DEPTH];
  logic [TS_BITS:0]    s1_word;
  logic                s1_v;
  logic                ev_acc;
  logic                rd_acc;
  logic [MEM_AW-1:0]   ev_addr;
  logic [MEM_AW-1:0]   rd_addr;
  logic [TS_BITS-1:0]  dt;
  logic [STEP_W-1:0]   steps;
  logic [FI_W-1:0]     frac;
  logic [VALUE_BITS-1:0] lut [LUT_N];
  logic [VALUE_BITS-1:0] decayed;

  // Single-channel builds drop the channel bit through the truncating cast.
  assign ev_addr     = MEM_AW'({event_ch, event_y, event_x});
  assign rd_addr     = MEM_AW'({read_ch, read_addr});
  assign ev_acc      = event_valid && ready;
  assign rd_acc      = read_enable && ready;
  assign event_ready = ready;
  assign read_ready  = ready;

  for (genvar f = 0; f < LUT_N; f++) begin : g_lut
    localparam real MANT = real'(MAX_VALUE) * (2.0 ** (-real'(f) / real'(LUT_N)));
    assign lut[f] = VALUE_BITS'($rtoi(MANT + 0.5));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
      ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clear_start) begin
            ptr <= '0;
          end else if (ptr == MEM_AW'(DEPTH - 1)) begin
            state <= S_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          if (clear_start) begin
            state <= S_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[ptr] <= '0;
    else if (ev_acc)      mem[ev_addr] <= {1'b1, event_ts};
  end

  // Nonblocking read of the array gives old-data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rd_acc) s1_word <= mem[rd_addr];
  end

  assign dt    = t_now - s1_word[TS_BITS-1:0];
  assign steps = dt[TS_BITS-1:DECAY_SHIFT];

  if (FRAC_BITS > 0) begin : g_frac
    assign frac = dt[DECAY_SHIFT-1 -: FRAC_BITS];
  end else begin : g_nofrac
    assign frac = '0;
  end

  // Anything older than half the timestamp range may have aliased; treat as fully decayed.
  assign decayed = (s1_word[TS_BITS] && !dt[TS_BITS-1] && (steps < STEP_W'(VALUE_BITS)))
                   ? (lut[frac] >> steps) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v        <= 1'b0;
      read_valid  <= 1'b0;
      read_value  <= '0;
      read_ts_raw <= '0;
    end else begin
      s1_v       <= rd_acc;
      read_valid <= s1_v;
      if (s1_v) begin
        read_value  <= decayed;
        read_ts_raw <= s1_word[TS_BITS-1:0];
      end
    end
  end

`ifdef TSE_EVENT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              event_count <= '0;
    else if (clear_start)                    event_count <= '0;
    else if (ev_acc && event_count != 16'hFFFF) event_count <= event_count + 16'd1;
  end
`else
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_time_surface_encoder_mc.sv
// tb/tb_time_surface_encoder_mc.sv - directed self-checking bench for time_surface_encoder_mc
module tb_time_surface_encoder_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] t_now = '0;
  logic        event_valid = 1'b0;
  logic        event_ready;
  logic        event_ch = 1'b0;
  logic [4:0]  event_x = '0;
  logic [4:0]  event_y = '0;
  logic [15:0] event_ts = '0;
  logic        read_enable = 1'b0;
  logic        read_ready;
  logic        read_ch = 1'b0;
  logic [9:0]  read_addr = '0;
  logic        read_valid;
  logic [7:0]  read_value;
  logic [15:0] read_ts_raw;
  logic        clear_start = 1'b0;
  logic        busy;
  logic [15:0] event_count;

  int checks = 0;
  int failures = 0;
  int ev_n = 0;
  int cyc;
  bit saw_rdy;

  time_surface_encoder_mc dut (
    .clk(clk), .rst_n(rst_n), .t_now(t_now),
    .event_valid(event_valid), .event_ready(event_ready), .event_ch(event_ch),
    .event_x(event_x), .event_y(event_y), .event_ts(event_ts),
    .read_enable(read_enable), .read_ready(read_ready), .read_ch(read_ch),
    .read_addr(read_addr), .read_valid(read_valid), .read_value(read_value),
    .read_ts_raw(read_ts_raw), .clear_start(clear_start), .busy(busy),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_count(input int n);
`ifdef TSE_EVENT_COUNT_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0;
`endif
  endfunction

  task automatic measure_busy(output int c, output bit rdy_seen);
    c = 0;
    rdy_seen = 0;
    while (busy === 1'b1 && c < 5000) begin
      if (event_ready !== 1'b0 || read_ready !== 1'b0) rdy_seen = 1;
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic send_event(input logic ch, input logic [4:0] x, input logic [4:0] y, input logic [15:0] ts);
    @(negedge clk);
    event_ch = ch; event_x = x; event_y = y; event_ts = ts; event_valid = 1'b1;
    chk("ev_ready", event_ready, 1);
    @(negedge clk);
    event_valid = 1'b0;
    ev_n++;
  endtask

  task automatic do_read(input logic ch, input logic [9:0] a, input logic [15:0] t,
                         input logic [7:0] ev, input logic [15:0] ets, input string tag);
    @(negedge clk);
    t_now = t; read_ch = ch; read_addr = a; read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    chk({tag, "_lat1"}, read_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, read_valid, 1);
    chk({tag, "_val"}, read_value, ev);
    chk({tag, "_ts"}, read_ts_raw, ets);
  endtask

  logic [7:0]  b2b_exp [4];
  logic [15:0] b2b_ts  [4];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ev_ready", event_ready, 0);
    chk("rst_rd_ready", read_ready, 0);
    chk("rst_rd_valid", read_valid, 0);
    chk("rst_rd_value", read_value, 0);
    chk("rst_rd_ts", read_ts_raw, 0);
    chk("rst_count", event_count, 0);

    rst_n = 1'b1;
    measure_busy(cyc, saw_rdy);
    chk("init_busy_cycles", cyc, 2048);
    chk("init_ready_during", saw_rdy, 0);
    chk("init_ev_ready", event_ready, 1);
    chk("init_rd_ready", read_ready, 1);
    do_read(1'b0, 10'd163, 16'd0, 8'd0, 16'd0, "empty");

    send_event(1'b0, 5'd3, 5'd5, 16'd1000);
    do_read(1'b0, 10'd163, 16'd1000, 8'd255, 16'd1000, "dt0");
    do_read(1'b0, 10'd163, 16'd1064, 8'd127, 16'd1000, "dt64");
    do_read(1'b0, 10'd163, 16'd1096, 8'd90,  16'd1000, "dt96");
    do_read(1'b0, 10'd163, 16'd1512, 8'd0,   16'd1000, "dt512");

    send_event(1'b1, 5'd0, 5'd0, 16'd65500);
    do_read(1'b1, 10'd0, 16'd36, 8'd127, 16'd65500, "wrap");
    do_read(1'b0, 10'd0, 16'd36, 8'd0, 16'd0, "other_ch");

    send_event(1'b0, 5'd1, 5'd0, 16'd0);
    do_read(1'b0, 10'd1, 16'd40000, 8'd0, 16'd0, "stale");

    b2b_ts[0] = 16'd2000; b2b_ts[1] = 16'd1936; b2b_ts[2] = 16'd1904; b2b_ts[3] = 16'd1872;
    b2b_exp[0] = 8'd255;  b2b_exp[1] = 8'd127;  b2b_exp[2] = 8'd90;   b2b_exp[3] = 8'd63;
    for (int i = 0; i < 4; i++) send_event(1'b0, 5'(10 + i), 5'd0, b2b_ts[i]);
    t_now = 16'd2000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("b2b%0d_valid", i - 2), read_valid, 1);
        chk($sformatf("b2b%0d_val", i - 2), read_value, b2b_exp[i-2]);
        chk($sformatf("b2b%0d_ts", i - 2), read_ts_raw, b2b_ts[i-2]);
      end
      read_ch = 1'b0;
      read_addr = 10'(10 + i);
      read_enable = (i < 4);
    end
    @(negedge clk);
    chk("b2b_end_valid", read_valid, 0);

    @(negedge clk);
    event_ch = 1'b0; event_x = 5'd20; event_y = 5'd0; event_ts = 16'd2000; event_valid = 1'b1;
    read_ch = 1'b0; read_addr = 10'd20; read_enable = 1'b1;
    @(negedge clk);
    event_valid = 1'b0; read_enable = 1'b0;
    ev_n++;
    @(negedge clk);
    chk("rdw_valid", read_valid, 1);
    chk("rdw_old_val", read_value, 0);
    chk("rdw_old_ts", read_ts_raw, 0);
    do_read(1'b0, 10'd20, 16'd2000, 8'd255, 16'd2000, "rdw_new");

    @(negedge clk);
    event_ch = 1'b1; event_x = 5'd7; event_y = 5'd7; event_ts = 16'd3000; event_valid = 1'b1;
    @(negedge clk);
    event_ts = 16'd3064;
    @(negedge clk);
    event_valid = 1'b0;
    ev_n += 2;
    do_read(1'b1, 10'd231, 16'd3064, 8'd255, 16'd3064, "last_wins");
    chk("count10", event_count, exp_count(ev_n));

    @(negedge clk);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    event_ch = 1'b0; event_x = 5'd3; event_y = 5'd5; event_ts = 16'd4000; event_valid = 1'b1;
    measure_busy(cyc, saw_rdy);
    event_valid = 1'b0;
    chk("clr_busy_cycles", cyc, 2048);
    chk("clr_ready_during", saw_rdy, 0);
    ev_n = 0;
    chk("clr_count", event_count, exp_count(ev_n));
    do_read(1'b0, 10'd163, 16'd4000, 8'd0, 16'd0, "clr_c0");
    do_read(1'b1, 10'd231, 16'd4000, 8'd0, 16'd0, "clr_c1");
    do_read(1'b0, 10'd20,  16'd4000, 8'd0, 16'd0, "clr_c2");
    do_read(1'b1, 10'd0,   16'd4000, 8'd0, 16'd0, "clr_c3");

    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1);
    chk("midrst_ready", event_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(cyc, saw_rdy);
    chk("midrst_busy_cycles", cyc, 2048);
    send_event(1'b0, 5'd2, 5'd2, 16'd5000);
    chk("count_after_rst", event_count, exp_count(ev_n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
